gvt_dispatch_ctrl: RTL and testbench
====================================

# gvt_dispatch_ctrl

Dispatch controller that feeds the GVT monitor and shares the global event queue among the simulation cores. Idle cores request work. The controller round-robin arbitrates between them, pops the queue head and hands the event to the winning core. It maintains the per-core `core_times`/`core_vld` vectors that the GVT monitor consumes, and throttles dispatch to a lookahead window above the current GVT.

## Interface

**Parameters**
- `NUM_CORE`, default 8: number of cores.
- `TIME_WID`, default 16: timestamp width.
- `EVT_WID`, default 32: event width. The timestamp is `evt[TIME_WID-1:0]`. `EVT_WID` must be greater than `TIME_WID`.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `core_req`, in, NUM_CORE: level request from an idle core.
- `core_done`, in, NUM_CORE: 1-cycle pulse when a core finishes its event.
- `core_grant`, out, NUM_CORE: one-hot, 1-cycle pulse that delivers `evt_out`.
- `evt_out`, out, EVT_WID: event being granted. Valid only while `core_grant` is nonzero; otherwise it holds its last value.
- `q_empty`, in, 1: event queue is empty.
- `q_head`, in, EVT_WID: queue head, valid when `q_empty` is 0.
- `q_deq`, out, 1: 1-cycle pop pulse.
- `gvt`, in, TIME_WID: current GVT from the GVT monitor (combinational from `core_times`, `core_vld` and the queue head).
- `window`, in, TIME_WID: lookahead bound.
- `core_times`, out, TIME_WID*NUM_CORE: timestamp of the event held by each core, packed as `core_times[TIME_WID*i +: TIME_WID]`.
- `core_vld`, out, NUM_CORE: core i currently holds an event.
- `win_stall`, out, 1: dispatch is blocked only by the window.

## Operation

- **FSM states:** IDLE, GRANT, SETTLE.
- **Eligible set:** `elig = core_req & ~core_vld`. A request from a core with `core_vld` set is ignored.
- **Window check:** `ok = ({1'b0,head_time} - {1'b0,gvt}) <= {1'b0,window}`.
  - Computed at TIME_WID+1 bits, unsigned.
  - If `head_time < gvt` (the difference goes negative), `ok` is 1.
  - Timestamps never wrap.
- **IDLE → GRANT** when `elig != 0`, `!q_empty` and `ok`.
  - Winner is the first set bit of `elig` at or after `rr_ptr`, searching upward with wrap.
  - Latch `evt_out <= q_head`.
  - Set `core_grant[w]`, `q_deq`, `core_vld[w]` and `core_times[w] <= head_time`.
  - Set `rr_ptr <= (w+1) mod NUM_CORE`.
- **GRANT → SETTLE:** unconditional. `core_grant` and `q_deq` return to 0.
- **SETTLE → IDLE:** unconditional. This cycle lets the queue present its new head and lets `gvt` reflect the new `core_vld`/`core_times`.
- **core_done[i]:** clears `core_vld[i]` at the next edge, in any state. `core_times[i]` holds its value. A `core_done` for a core whose `core_vld` is 0 is ignored.
- **Simultaneous done and grant:** a grant can only go to a core whose `core_vld` is 0, so a done pulse in the same cycle for that core is ignored. Done pulses for other cores are applied in that same edge.
- **win_stall:** equals 1 in IDLE when `elig != 0`, `!q_empty` and `!ok`. It is 0 in all other cases.
- **Reset** (`rst_n`=0 at an edge, including mid-dispatch):
  - state goes to IDLE.
  - `core_grant`, `q_deq`, `evt_out`, `core_times`, `core_vld` and `rr_ptr` all go to 0.
  - `win_stall` is 0.
  - A grant in progress is dropped. The queue must be reset together with this block.

## Timing

- All outputs are registered except `win_stall`, which is combinational from state and inputs.
- A request seen in IDLE at edge N produces `core_grant`, `q_deq` and `evt_out` during cycle N+1. `core_vld` and `core_times` update at the same edge N.
- Maximum throughput is one dispatch per 3 cycles. A request held continuously is re-arbitrated in the IDLE cycle after SETTLE.
- Done-to-`core_vld`-clear latency is 1 cycle. A core becomes eligible again on the cycle after its `core_vld` clears.
- `q_deq` is exactly one cycle wide. The controller never pops while `q_empty` is 1.

## Test plan

1. **Reset:** hold `rst_n`=0 for 2 cycles with `core_req`=8'hFF. Required: all outputs are 0, no grant and no `q_deq`.
2. **Single dispatch:**
   - Stimulus: `q_head`=32'h0000_0025, `gvt`=16'h25, `window`=16'h10, `core_req`=8'h02.
   - Required: `core_grant`=8'h02 and `q_deq`=1 for one cycle, `evt_out`=32'h25.
   - Required: `core_vld`=8'h02 and `core_times[16 +: 16]`=16'h25.
   - Required: next grant no sooner than 3 cycles later.
3. **Round-robin:** `core_req`=8'h0B held, queue non-empty, window large. Required: grants go to cores 0, 1, 3, then 0 again after `core_done` pulses. `core_vld` tracks each grant and done.
4. **Window stall:**
   - Stimulus: `gvt`=16'h10, `window`=16'h08, `q_head` time 16'h19.
   - Required: `win_stall`=1 and no grant.
   - Then drop `q_head` time to 16'h18. Required: grant on the next cycle and `win_stall`=0.
5. **Empty queue / stale request:**
   - `q_empty`=1 with requests pending. Required: no `q_deq`, `win_stall`=0.
   - A request from a core that already has `core_vld`=1 is never granted until its `core_done` pulse.
6. **Reset mid-dispatch:** assert `rst_n`=0 during GRANT. Required: at the next edge `core_grant`=0, `core_vld`=0 and state is IDLE. After release, the grant goes to core 0 first.

Source files
------------

// File: rtl/gvt_dispatch_ctrl.sv
// Dispatch controller: round-robin hands queue-head events to idle cores,
// tracks per-core held timestamps for the GVT monitor and throttles on the lookahead window.
module gvt_dispatch_ctrl #(
  parameter int NUM_CORE = 8,
  parameter int TIME_WID = 16,
  parameter int EVT_WID  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CORE-1:0]          core_req,
  input  logic [NUM_CORE-1:0]          core_done,
  output logic [NUM_CORE-1:0]          core_grant,
  output logic [EVT_WID-1:0]           evt_out,
  input  logic                         q_empty,
  input  logic [EVT_WID-1:0]           q_head,
  output logic                         q_deq,
  input  logic [TIME_WID-1:0]          gvt,
  input  logic [TIME_WID-1:0]          window,
  output logic [TIME_WID*NUM_CORE-1:0] core_times,
  output logic [NUM_CORE-1:0]          core_vld,
  output logic                         win_stall
);

  localparam int PTR_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_CORE-1:0]          core_grant_q, core_grant_d;
  logic [NUM_CORE-1:0]          core_vld_q, core_vld_d;
  logic                         q_deq_q, q_deq_d;
  logic [EVT_WID-1:0]           evt_out_q, evt_out_d;
  logic [TIME_WID*NUM_CORE-1:0] core_times_q, core_times_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;

  logic [TIME_WID-1:0]   head_time;
  logic [TIME_WID:0]     win_diff;
  logic                  win_ok;
  logic [NUM_CORE-1:0]   elig;
  logic                  dispatch;
  logic [2*NUM_CORE-1:0] elig_rot;
  logic [PTR_W-1:0]      win_off;
  logic [PTR_W:0]        win_sum;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W:0]        ptr_nxt;
  logic [NUM_CORE-1:0]   win_onehot;

  assign head_time = q_head[TIME_WID-1:0];

  // A negative difference (head behind GVT) always passes the window.
  assign win_diff = {1'b0, head_time} - {1'b0, gvt};
  assign win_ok   = win_diff[TIME_WID] || (win_diff <= {1'b0, window});

  assign elig      = core_req & ~core_vld_q;
  assign dispatch  = (state_q == IDLE) && (|elig) && !q_empty && win_ok;
  assign win_stall = (state_q == IDLE) && (|elig) && !q_empty && !win_ok;

  // Rotate so the search starts at rr_ptr; first set bit gives the offset.
  always_comb begin
    elig_rot = {elig, elig} >> rr_ptr_q;
    win_off  = '0;
    for (int k = NUM_CORE - 1; k >= 0; k--) begin
      if (elig_rot[k]) win_off = PTR_W'(k);
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= (PTR_W+1)'(NUM_CORE)) win_sum = win_sum - (PTR_W+1)'(NUM_CORE);
    win_idx = win_sum[PTR_W-1:0];
    ptr_nxt = {1'b0, win_idx} + 1'b1;
    if (ptr_nxt >= (PTR_W+1)'(NUM_CORE)) ptr_nxt = '0;
    win_onehot = NUM_CORE'(1) << win_idx;
  end

  always_comb begin
    state_d      = state_q;
    core_grant_d = '0;
    q_deq_d      = 1'b0;
    evt_out_d    = evt_out_q;
    core_times_d = core_times_q;
    rr_ptr_d     = rr_ptr_q;
    // Done pulses apply in every state; a pulse for an empty core is a no-op.
    core_vld_d   = core_vld_q & ~core_done;

    case (state_q)
      IDLE: begin
        if (dispatch) begin
          state_d      = GRANT;
          core_grant_d = win_onehot;
          q_deq_d      = 1'b1;
          evt_out_d    = q_head;
          core_vld_d   = core_vld_d | win_onehot;
          rr_ptr_d     = ptr_nxt[PTR_W-1:0];
          for (int i = 0; i < NUM_CORE; i++) begin
            if (win_onehot[i]) core_times_d[TIME_WID*i +: TIME_WID] = head_time;
          end
        end
      end
      GRANT:   state_d = SETTLE;
      // Extra cycle so the queue head and gvt catch up with the new core state.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      core_grant_q <= '0;
      q_deq_q      <= 1'b0;
      evt_out_q    <= '0;
      core_times_q <= '0;
      core_vld_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      core_grant_q <= core_grant_d;
      q_deq_q      <= q_deq_d;
      evt_out_q    <= evt_out_d;
      core_times_q <= core_times_d;
      core_vld_q   <= core_vld_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign core_grant = core_grant_q;
  assign q_deq      = q_deq_q;
  assign evt_out    = evt_out_q;
  assign core_times = core_times_q;
  assign core_vld   = core_vld_q;

endmodule

// File: tb/tb_gvt_dispatch_ctrl.sv
// Directed bench for gvt_dispatch_ctrl: reset, dispatch latency, round-robin,
// window throttling, empty queue / stale requests and reset during a grant.
module tb_gvt_dispatch_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   core_req;
  logic [7:0]   core_done;
  logic [7:0]   core_grant;
  logic [31:0]  evt_out;
  logic         q_empty;
  logic [31:0]  q_head;
  logic         q_deq;
  logic [15:0]  gvt;
  logic [15:0]  window;
  logic [127:0] core_times;
  logic [7:0]   core_vld;
  logic         win_stall;

  int n_tests = 0;
  int n_fail  = 0;

  gvt_dispatch_ctrl #(.NUM_CORE(8), .TIME_WID(16), .EVT_WID(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_done  (core_done),
    .core_grant (core_grant),
    .evt_out    (evt_out),
    .q_empty    (q_empty),
    .q_head     (q_head),
    .q_deq      (q_deq),
    .gvt        (gvt),
    .window     (window),
    .core_times (core_times),
    .core_vld   (core_vld),
    .win_stall  (win_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with all cores requesting
    rst_n = 1'b0; core_req = 8'hFF; core_done = 8'h00;
    q_empty = 1'b0; q_head = 32'h0000_0025; gvt = 16'h0; window = 16'hFFFF;
    tick(); tick();
    chk("rst_grant", core_grant, 0);
    chk("rst_deq",   q_deq, 0);
    chk("rst_evt",   evt_out, 0);
    chk("rst_vld",   core_vld, 0);
    chk("rst_times", core_times, 0);
    chk("rst_stall", win_stall, 0);

    // 2. Single dispatch to core 1
    core_req = 8'h02; gvt = 16'h25; window = 16'h10;
    rst_n = 1'b1;
    tick();
    chk("sd_grant", core_grant, 8'h02);
    chk("sd_deq",   q_deq, 1);
    chk("sd_evt",   evt_out, 32'h0000_0025);
    chk("sd_vld",   core_vld, 8'h02);
    chk("sd_time1", core_times[31:16], 16'h25);
    core_req = 8'h03; q_head = 32'hA000_0026;
    tick();
    chk("sd_g_n1",   core_grant, 0);
    chk("sd_deq_n1", q_deq, 0);
    chk("sd_evt_hold", evt_out, 32'h0000_0025);
    tick();
    chk("sd_g_n2", core_grant, 0);
    tick();
    chk("sd_g_n3",  core_grant, 8'h01);
    chk("sd_evt2",  evt_out, 32'hA000_0026);
    chk("sd_time0", core_times[15:0], 16'h26);
    chk("sd_vld2",  core_vld, 8'h03);
    core_req = 8'h00; core_done = 8'h03;
    tick();
    chk("sd_done_vld",  core_vld, 8'h00);
    chk("sd_time_hold", core_times[31:16], 16'h25);
    core_done = 8'h00;
    tick();

    // 3. Round-robin over cores 0,1,3 from a fresh pointer
    rst_n = 1'b0; tick();
    rst_n = 1'b1; core_req = 8'h0B; gvt = 16'h0; window = 16'hFFFF; q_head = 32'h0000_0030;
    tick();
    chk("rr_g0", core_grant, 8'h01);
    chk("rr_v0", core_vld, 8'h01);
    tick(); tick();
    chk("rr_gap", core_grant, 0);
    tick();
    chk("rr_g1", core_grant, 8'h02);
    chk("rr_v1", core_vld, 8'h03);
    tick(); tick(); tick();
    chk("rr_g3", core_grant, 8'h08);
    chk("rr_v3", core_vld, 8'h0B);
    tick(); tick(); tick();
    chk("rr_none", core_grant, 0);
    core_done = 8'h01;
    tick();
    chk("rr_done_vld", core_vld, 8'h0A);
    core_done = 8'h00;
    tick();
    chk("rr_g0_again", core_grant, 8'h01);
    chk("rr_v0_again", core_vld, 8'h0B);
    core_req = 8'h00; core_done = 8'h0B;
    tick();
    chk("rr_clear", core_vld, 8'h00);
    core_done = 8'h00;
    tick();

    // 4. Window stall, then release at the exact window edge
    core_req = 8'h04; gvt = 16'h10; window = 16'h08; q_head = 32'h0000_0019;
    #1;
    chk("ws_stall", win_stall, 1);
    tick();
    chk("ws_nogrant", core_grant, 0);
    chk("ws_stall2",  win_stall, 1);
    q_head = 32'h0000_0018;
    #1;
    chk("ws_ok", win_stall, 0);
    tick();
    chk("ws_grant",  core_grant, 8'h04);
    chk("ws_stall3", win_stall, 0);
    chk("ws_time2",  core_times[47:32], 16'h18);
    core_req = 8'h00; core_done = 8'h04;
    tick();
    core_done = 8'h00;
    tick();

    // 5. Empty queue, head behind GVT, stale request
    q_empty = 1'b1; core_req = 8'hFF; gvt = 16'h0; window = 16'h0; q_head = 32'h0000_0005;
    #1;
    chk("eq_stall", win_stall, 0);
    tick();
    chk("eq_deq",   q_deq, 0);
    chk("eq_grant", core_grant, 0);
    tick();
    chk("eq_deq2", q_deq, 0);
    q_empty = 1'b0; core_req = 8'h10; gvt = 16'h40; q_head = 32'h0000_0020;
    #1;
    chk("neg_stall", win_stall, 0);
    tick();
    chk("neg_grant", core_grant, 8'h10);
    chk("neg_time4", core_times[79:64], 16'h20);
    tick(); tick(); tick();
    chk("stale_grant", core_grant, 0);
    chk("stale_stall", win_stall, 0);
    tick();
    chk("stale_grant2", core_grant, 0);
    core_done = 8'h10;
    tick();
    chk("stale_vld", core_vld, 8'h00);
    core_done = 8'h00;
    tick();
    chk("stale_regrant", core_grant, 8'h10);

    // 6. Reset while in GRANT
    core_req = 8'hFF; window = 16'hFFFF; gvt = 16'h0;
    rst_n = 1'b0;
    tick();
    chk("mr_grant", core_grant, 0);
    chk("mr_vld",   core_vld, 0);
    chk("mr_deq",   q_deq, 0);
    chk("mr_evt",   evt_out, 0);
    rst_n = 1'b1;
    tick();
    chk("mr_first", core_grant, 8'h01);
    chk("mr_deq2",  q_deq, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
